// File: rtl/calc1_if.sv
// calc1 client bus: four request ports, four response ports.
// Bit 0 of every bus is the MSB.
interface calc1_if;
  logic [0:3]  req1_cmd_in;
  logic [0:3]  req2_cmd_in;
  logic [0:3]  req3_cmd_in;
  logic [0:3]  req4_cmd_in;
  logic [0:31] req1_data_in;
  logic [0:31] req2_data_in;
  logic [0:31] req3_data_in;
  logic [0:31] req4_data_in;
  logic [0:31] out_data1;
  logic [0:31] out_data2;
  logic [0:31] out_data3;
  logic [0:31] out_data4;
  logic [0:1]  out_resp1;
  logic [0:1]  out_resp2;
  logic [0:1]  out_resp3;
  logic [0:1]  out_resp4;

  modport master (
    output req1_cmd_in, req2_cmd_in,
    output req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in,
    output req3_data_in, req4_data_in,
    input  out_data1, out_data2,
    input  out_data3, out_data4,
    input  out_resp1, out_resp2,
    input  out_resp3, out_resp4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in,
    input  req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in,
    input  req3_data_in, req4_data_in,
    output out_data1, out_data2,
    output out_data3, out_data4,
    output out_resp1, out_resp2,
    output out_resp3, out_resp4
  );
endinterface

// File: rtl/calc1.sv
// Four-port calculator sharing one add/sub and one shift unit.
// Define CALC1_RR_ARB_EN for round-robin instead of fixed priority.
module calc1 (
  input  logic       c_clk,
  input  logic [1:7] reset,
  calc1_if.slave     bus
);
  typedef enum logic [1:0] {
    IDLE, OP2, WAIT, RESP
  } st_e;

  logic rst;
  assign rst = |reset;

  logic [0:3]  cmd_i [4];
  logic [0:31] dat_i [4];
  assign cmd_i[0] = bus.req1_cmd_in;
  assign cmd_i[1] = bus.req2_cmd_in;
  assign cmd_i[2] = bus.req3_cmd_in;
  assign cmd_i[3] = bus.req4_cmd_in;
  assign dat_i[0] = bus.req1_data_in;
  assign dat_i[1] = bus.req2_data_in;
  assign dat_i[2] = bus.req3_data_in;
  assign dat_i[3] = bus.req4_data_in;

  st_e         st_q   [4];
  logic [0:3]  cmd_q  [4];
  logic [0:31] op1_q  [4];
  logic [0:31] op2_q  [4];
  logic [0:31] data_q [4];
  logic [0:1]  resp_q [4];

  assign bus.out_data1 = data_q[0];
  assign bus.out_data2 = data_q[1];
  assign bus.out_data3 = data_q[2];
  assign bus.out_data4 = data_q[3];
  assign bus.out_resp1 = resp_q[0];
  assign bus.out_resp2 = resp_q[1];
  assign bus.out_resp3 = resp_q[2];
  assign bus.out_resp4 = resp_q[3];

  logic [3:0] rq_a, rq_s, g_a, g_s;
  logic [1:0] pa_q, ps_q;

  always_comb begin
    rq_a = '0;
    rq_s = '0;
    for (int i = 0; i < 4; i++) begin
      rq_a[i] = (st_q[i] == WAIT) &&
        (cmd_q[i] == 4'd1 || cmd_q[i] == 4'd2);
      rq_s[i] = (st_q[i] == WAIT) &&
        (cmd_q[i] == 4'd5 || cmd_q[i] == 4'd6);
    end
  end

  // First requester at or after ptr wins; ptr 0 is plain 1>2>3>4.
  function automatic logic [3:0] arb(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    logic [1:0] idx;
    arb = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) arb = 4'b1 << idx;
    end
  endfunction

  assign g_a = arb(rq_a, pa_q);
  assign g_s = arb(rq_s, ps_q);

`ifdef CALC1_RR_ARB_EN
  function automatic logic [1:0] enc(
    input logic [3:0] g
  );
    enc = '0;
    for (int k = 0; k < 4; k++)
      if (g[k]) enc = 2'(k);
  endfunction

  logic [1:0] pa_d, ps_d;
  always_comb begin
    pa_d = pa_q;
    ps_d = ps_q;
    if (|g_a) pa_d = enc(g_a) + 2'd1;
    if (|g_s) ps_d = enc(g_s) + 2'd1;
  end

  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      pa_q <= '0;
      ps_q <= '0;
    end else begin
      pa_q <= pa_d;
      ps_q <= ps_d;
    end
  end
`else
  assign pa_q = '0;
  assign ps_q = '0;
`endif

  logic [0:31] a_x, a_y, s_x;
  logic [0:4]  s_n;
  logic        a_sub, s_left;

  always_comb begin
    a_x    = '0;
    a_y    = '0;
    a_sub  = 1'b0;
    s_x    = '0;
    s_n    = '0;
    s_left = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (g_a[i]) begin
        a_x   = op1_q[i];
        a_y   = op2_q[i];
        a_sub = (cmd_q[i] == 4'd2);
      end
      if (g_s[i]) begin
        s_x    = op1_q[i];
        s_n    = op2_q[i][27:31];
        s_left = (cmd_q[i] == 4'd5);
      end
    end
  end

  logic [32:0] sum;
  logic [0:31] a_res, s_res;
  logic [0:1]  a_rsp;
  assign sum = {1'b0, a_x} + {1'b0, a_y};

  always_comb begin
    a_rsp = 2'd1;
    a_res = '0;
    if (a_sub) begin
      if (a_x < a_y) a_rsp = 2'd2;
      else a_res = a_x - a_y;
    end else begin
      if (sum[32]) a_rsp = 2'd2;
      else a_res = sum[31:0];
    end
  end

  assign s_res = s_left ? (s_x << s_n)
                        : (s_x >> s_n);

  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]   <= IDLE;
        cmd_q[i]  <= '0;
        op1_q[i]  <= '0;
        op2_q[i]  <= '0;
        data_q[i] <= '0;
        resp_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        unique case (st_q[i])
          IDLE: if (cmd_i[i] != 4'd0) begin
            cmd_q[i] <= cmd_i[i];
            op1_q[i] <= dat_i[i];
            st_q[i]  <= OP2;
          end
          OP2: begin
            op2_q[i] <= dat_i[i];
            st_q[i]  <= WAIT;
          end
          WAIT: begin
            if (!(cmd_q[i] inside
                {4'd1, 4'd2, 4'd5, 4'd6})) begin
              resp_q[i] <= 2'd2;
              data_q[i] <= '0;
              st_q[i]   <= RESP;
            end else if (g_a[i]) begin
              resp_q[i] <= a_rsp;
              data_q[i] <= a_res;
              st_q[i]   <= RESP;
            end else if (g_s[i]) begin
              resp_q[i] <= 2'd1;
              data_q[i] <= s_res;
              st_q[i]   <= RESP;
            end
          end
          RESP: begin
            resp_q[i] <= '0;
            data_q[i] <= '0;
            st_q[i]   <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_calc1.sv
// Scoreboard bench for calc1: directed vectors, decoupled monitor.
module tb_calc1;
  logic clk = 1'b0;
  logic [1:7] rst_v;
  always #5 clk = ~clk;

  calc1_if bus ();
  calc1 dut (
    .c_clk(clk),
    .reset(rst_v),
    .bus  (bus)
  );

  logic [3:0]  tcmd  [4];
  logic [31:0] tdat  [4];
  logic [1:0]  oresp [4];
  logic [31:0] odat  [4];

  assign bus.req1_cmd_in  = tcmd[0];
  assign bus.req2_cmd_in  = tcmd[1];
  assign bus.req3_cmd_in  = tcmd[2];
  assign bus.req4_cmd_in  = tcmd[3];
  assign bus.req1_data_in = tdat[0];
  assign bus.req2_data_in = tdat[1];
  assign bus.req3_data_in = tdat[2];
  assign bus.req4_data_in = tdat[3];
  assign oresp[0] = bus.out_resp1;
  assign oresp[1] = bus.out_resp2;
  assign oresp[2] = bus.out_resp3;
  assign oresp[3] = bus.out_resp4;
  assign odat[0]  = bus.out_data1;
  assign odat[1]  = bus.out_data2;
  assign odat[2]  = bus.out_data3;
  assign odat[3]  = bus.out_data4;

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] want
  );
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, want);
    end
  endtask

  initial begin
    int idx;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        if (oresp[p] != 2'd0) begin
          idx = -1;
          for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].port == p) idx = k;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected p%0d: resp %0d data %h",
                     p + 1, oresp[p], odat[p]);
          end else begin
            chk($sformatf("resp p%0d", p + 1),
                32'(oresp[p]), 32'(sb[idx].resp));
            chk($sformatf("data p%0d", p + 1),
                odat[p], sb[idx].data);
            chk($sformatf("cycle p%0d", p + 1),
                cyc, sb[idx].cyc);
            sb.delete(idx);
          end
        end else if (odat[p] != 32'd0) begin
          checks++;
          errors++;
          $display("FAIL idle_data p%0d: got %h want 0",
                   p + 1, odat[p]);
        end
      end
    end
  end

  task automatic req(
    input int          p,
    input logic [3:0]  c,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [1:0]  er,
    input logic [31:0] ed,
    input bit          hold
  );
    exp_t e;
    @(negedge clk);
    tcmd[p] = c;
    tdat[p] = a;
    @(posedge clk);
    #1;
    e.port = p;
    e.resp = er;
    e.data = ed;
    e.cyc  = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
    tcmd[p] = hold ? c : 4'd0;
    tdat[p] = b;
    @(posedge clk);
    @(negedge clk);
    tdat[p] = '0;
    if (hold) begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      tcmd[p] = '0;
    end
    repeat (3) @(negedge clk);
  endtask

  logic [3:0]  mc [4];
  logic [31:0] ma [4];
  logic [31:0] mb [4];
  logic [1:0]  mr [4];
  logic [31:0] md [4];
  int          mx [4];

  task automatic multi(input logic [3:0] m);
    exp_t e;
    @(negedge clk);
    for (int p = 0; p < 4; p++)
      if (m[p]) begin
        tcmd[p] = mc[p];
        tdat[p] = ma[p];
      end
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++)
      if (m[p]) begin
        e.port = p;
        e.resp = mr[p];
        e.data = md[p];
        e.cyc  = cyc + 2 + mx[p];
        sb.push_back(e);
      end
    @(negedge clk);
    for (int p = 0; p < 4; p++)
      if (m[p]) begin
        tcmd[p] = '0;
        tdat[p] = mb[p];
      end
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 4; p++)
      if (m[p]) tdat[p] = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_v[2] = 1'b1;
    @(negedge clk);
    rst_v = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = 7'b1000000;
    for (int p = 0; p < 4; p++) begin
      tcmd[p] = '0;
      tdat[p] = '0;
    end
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_resp p%0d", p + 1),
          32'(oresp[p]), 32'd0);
      chk($sformatf("rst_data p%0d", p + 1),
          odat[p], 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_v = '0;

    req(0, 4'd1, 32'h1, 32'h1FFFFFFF,
        2'd1, 32'h20000000, 1'b0);
    req(0, 4'd1, 32'h1FFFFFFF, 32'h1FFFFFFF,
        2'd1, 32'h3FFFFFFE, 1'b0);
    req(0, 4'd1, 32'h0, 32'h0, 2'd1, 32'h0, 1'b1);
    req(1, 4'd1, 32'hFFFFFFFF, 32'h1,
        2'd2, 32'h0, 1'b0);
    req(2, 4'd2, 32'd5, 32'd6, 2'd2, 32'h0, 1'b0);
    req(2, 4'd2, 32'd6, 32'd5, 2'd1, 32'h1, 1'b0);
    req(2, 4'd2, 32'd7, 32'd7, 2'd1, 32'h0, 1'b1);
    req(3, 4'd5, 32'h1, 32'h24,
        2'd1, 32'h10, 1'b0);
    req(3, 4'd6, 32'h80000000, 32'd31,
        2'd1, 32'h1, 1'b0);
    req(3, 4'd6, 32'hA5A5A5A5, 32'hFFFFFFE0,
        2'd1, 32'hA5A5A5A5, 1'b0);
    req(0, 4'd3, 32'h5, 32'h6, 2'd2, 32'h0, 1'b0);
    req(1, 4'd15, 32'h5, 32'h6, 2'd2, 32'h0, 1'b0);

    do_reset();
    for (int p = 0; p < 4; p++) begin
      mc[p] = 4'd1;
      ma[p] = 32'd1;
      mb[p] = 32'd1;
      mr[p] = 2'd1;
      md[p] = 32'd2;
      mx[p] = p;
    end
    multi(4'b1111);

    do_reset();
    mc[0] = 4'd1; ma[0] = 32'd10; mb[0] = 32'd20;
    mr[0] = 2'd1; md[0] = 32'd30; mx[0] = 0;
    mc[1] = 4'd5; ma[1] = 32'h3; mb[1] = 32'd8;
    mr[1] = 2'd1; md[1] = 32'h300; mx[1] = 0;
    mc[2] = 4'd2; ma[2] = 32'd9; mb[2] = 32'd4;
    mr[2] = 2'd1; md[2] = 32'd5; mx[2] = 1;
    mc[3] = 4'd7; ma[3] = 32'd1; mb[3] = 32'd1;
    mr[3] = 2'd2; md[3] = 32'd0; mx[3] = 0;
    multi(4'b1111);

    @(negedge clk);
    tcmd[1] = 4'd1;
    tdat[1] = 32'd1;
    @(posedge clk);
    @(negedge clk);
    tcmd[1] = '0;
    tdat[1] = 32'd1;
    tcmd[2] = 4'd2;
    tdat[2] = 32'd9;
    @(posedge clk);
    @(negedge clk);
    tdat[1] = '0;
    tcmd[2] = '0;
    tdat[2] = 32'd4;
    @(posedge clk);
    #2;
    chk("pre_rst resp p2", 32'(oresp[1]), 32'd1);
    chk("pre_rst data p2", odat[1], 32'd2);
    #1;
    rst_v = 7'b0001000;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("abort_resp p%0d", p + 1),
          32'(oresp[p]), 32'd0);
      chk($sformatf("abort_data p%0d", p + 1),
          odat[p], 32'd0);
    end
    @(negedge clk);
    tdat[2] = '0;
    repeat (2) @(negedge clk);
    rst_v = '0;
    repeat (8) @(negedge clk);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing p%0d: got none want resp %0d",
               sb[0].port + 1, sb[0].resp);
      sb.delete(0);
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
